// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store memory sequencer: funct3 codes, FSM
// states and small decode helpers.
package mem_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            LB, LBU: size_of = 3'd1;
            LH, LHU: size_of = 3'd2;
            LW:      size_of = 3'd4;
            default: size_of = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            is_legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            is_legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                       (funct3 == LBU) || (funct3 == LHU);
        end
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bundle and memory-side port bundle.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface mem_port_if #(parameter int ADDR_W = 10);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_rdata);
endinterface

// File: rtl/mem_access_ctrl_lsu_lane_align.sv
// Byte-lane steering: enables, boundary-split detect, store data shift and
// load data extract/extend.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rword,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic        o_split,
    output logic [63:0] o_wdata_sh,
    output logic [31:0] o_rdata_ext
);

    logic [3:0]  w_mask;
    logic [7:0]  w_be_wide;
    logic [3:0]  w_sum;
    logic [31:0] w_wdata_m;
    logic [31:0] w_rd_lo;

    assign w_mask    = size_mask(i_size);
    assign w_be_wide = {4'b0000, w_mask} << i_off;
    assign o_be0     = w_be_wide[3:0];
    assign o_be1     = w_be_wide[7:4];
    assign w_sum     = {2'b00, i_off} + {1'b0, i_size};
    assign o_split   = (w_sum > 4'd4);

    // Lanes beyond the access size are zeroed before shifting into place.
    assign w_wdata_m  = i_wdata & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    assign o_wdata_sh = {32'd0, w_wdata_m} << {i_off, 3'b000};
    assign w_rd_lo    = 32'(i_rword >> {i_off, 3'b000});

    // Truncate the shifted read word to the access size and extend it.
    always_comb begin
        case (i_size)
            3'd1:    o_rdata_ext = {{24{i_sign & w_rd_lo[7]}}, w_rd_lo[7:0]};
            3'd2:    o_rdata_ext = {{16{i_sign & w_rd_lo[15]}}, w_rd_lo[15:0]};
            default: o_rdata_ext = w_rd_lo;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one request in flight, one or two word accesses,
// merged and extended load data, one response pulse per request.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W           = 10,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   core,
    mem_port_if.master mem
);

    state_t            r_state, w_state_nxt;
    logic              r_we, r_err;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata, r_lo, r_result;
    logic              r_mem_req, r_mem_we, r_rsp_valid, r_rsp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata, r_rsp_rdata;

    logic              w_mem_req_nxt, w_mem_we_nxt, w_rsp_valid_nxt, w_rsp_err_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [3:0]        w_mem_be_nxt;
    logic [31:0]       w_mem_wdata_nxt, w_rsp_rdata_nxt;

    logic              w_idle, w_accept, w_we, w_err_req, w_split, w_unused_addr;
    logic [2:0]        w_funct3;
    logic [ADDR_W+1:0] w_addr;
    logic [31:0]       w_wdata, w_rdata_ext;
    logic [ADDR_W-1:0] w_word0, w_word1;
    logic [3:0]        w_be0, w_be1;
    logic [63:0]       w_wdata_sh, w_rword;

    assign w_idle         = (r_state == ST_IDLE);
    assign core.req_ready = w_idle & rst_n;
    assign w_accept       = core.req_valid & w_idle;

    // In IDLE the live request fields steer the datapath so the first access
    // can be registered on the accept edge; afterwards the latched copy does.
    assign w_we          = w_idle ? core.req_we : r_we;
    assign w_funct3      = w_idle ? core.req_funct3 : r_funct3;
    assign w_addr        = w_idle ? core.req_addr[ADDR_W+1:0] : r_addr;
    assign w_wdata       = w_idle ? core.req_wdata : r_wdata;
    assign w_unused_addr = ^core.req_addr[31:ADDR_W+2];

    assign w_word0   = w_addr[ADDR_W+1:2];
    assign w_word1   = w_word0 + ADDR_W'(1);
    assign w_rword   = w_split ? {mem.mem_rdata, r_lo} : {32'd0, mem.mem_rdata};
    assign w_err_req = !is_legal(w_we, w_funct3) || (w_split && !ALLOW_MISALIGNED);

    lsu_lane_align u_align (
        .i_off       (w_addr[1:0]),
        .i_size      (size_of(w_funct3)),
        .i_sign      (~w_funct3[2]),
        .i_wdata     (w_wdata),
        .i_rword     (w_rword),
        .o_be0       (w_be0),
        .o_be1       (w_be1),
        .o_split     (w_split),
        .o_wdata_sh  (w_wdata_sh),
        .o_rdata_ext (w_rdata_ext)
    );

    // Next state plus next values of the registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_be_nxt    = 4'b0000;
        w_mem_wdata_nxt = 32'd0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_err_req) begin
                    w_state_nxt = ST_RESP;
                end else if (w_accept) begin
                    w_state_nxt     = ST_ACC0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = w_we;
                    w_mem_addr_nxt  = w_word0;
                    w_mem_be_nxt    = w_be0;
                    w_mem_wdata_nxt = w_we ? w_wdata_sh[31:0] : 32'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (w_split) begin
                    w_state_nxt     = ST_ACC1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = r_we;
                    w_mem_addr_nxt  = w_word1;
                    w_mem_be_nxt    = w_be1;
                    w_mem_wdata_nxt = r_we ? w_wdata_sh[63:32] : 32'd0;
                end else begin
                    w_state_nxt = ST_CAPT;
                end
            end
            ST_ACC1: w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = ST_RESP;
            ST_RESP: begin
                w_state_nxt     = ST_IDLE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = r_err;
                w_rsp_rdata_nxt = r_result;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Registered memory-port and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    // Request latch, low-word capture for split loads, and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_lo     <= 32'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_we     <= core.req_we;
            r_err    <= w_err_req;
            r_funct3 <= core.req_funct3;
            r_addr   <= core.req_addr[ADDR_W+1:0];
            r_wdata  <= core.req_wdata;
            r_result <= 32'd0;
        end else if ((r_state == ST_ACC1) && !r_we) begin
            r_lo <= mem.mem_rdata;
        end else if ((r_state == ST_CAPT) && !r_we) begin
            r_result <= w_rdata_ext;
        end
    end

    assign mem.mem_req    = r_mem_req;
    assign mem.mem_we     = r_mem_we;
    assign mem.mem_addr   = r_mem_addr;
    assign mem.mem_be     = r_mem_be;
    assign mem.mem_wdata  = r_mem_wdata;
    assign core.rsp_valid = r_rsp_valid;
    assign core.rsp_err   = r_rsp_err;
    assign core.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one split-capable instance backed by a
// synchronous-read memory model, one instance that rejects misalignment.
module tb_mem_access_ctrl;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if                  if_a ();
    mem_port_if #(.ADDR_W(AW))  mp_a ();
    lsu_req_if                  if_b ();
    mem_port_if #(.ADDR_W(AW))  mp_b ();

    mem_access_ctrl #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .core(if_a), .mem(mp_a));
    mem_access_ctrl #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .core(if_b), .mem(mp_b));

    assign mp_b.mem_rdata = 32'hFFFF_0000;

    logic [31:0] mem_arr [0:(1<<AW)-1];
    logic [31:0] rd_q;
    assign mp_a.mem_rdata = rd_q;

    // Synchronous-read, byte-enabled memory.
    always @(posedge clk) begin
        if (mp_a.mem_req) begin
            if (mp_a.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mp_a.mem_be[b]) mem_arr[mp_a.mem_addr][8*b +: 8] <= mp_a.mem_wdata[8*b +: 8];
            end else begin
                rd_q <= mem_arr[mp_a.mem_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cur_sel = 0;

    logic          o_ready, o_rsp_valid, o_rsp_err, o_mem_req, o_mem_we;
    logic [31:0]   o_rdata, o_wdata;
    logic [AW-1:0] o_addr;
    logic [3:0]    o_be;

    always_comb begin
        if (cur_sel == 0) begin
            o_ready = if_a.req_ready; o_rsp_valid = if_a.rsp_valid; o_rsp_err = if_a.rsp_err;
            o_rdata = if_a.rsp_rdata; o_mem_req = mp_a.mem_req; o_mem_we = mp_a.mem_we;
            o_addr = mp_a.mem_addr; o_be = mp_a.mem_be; o_wdata = mp_a.mem_wdata;
        end else begin
            o_ready = if_b.req_ready; o_rsp_valid = if_b.rsp_valid; o_rsp_err = if_b.rsp_err;
            o_rdata = if_b.rsp_rdata; o_mem_req = mp_b.mem_req; o_mem_we = mp_b.mem_we;
            o_addr = mp_b.mem_addr; o_be = mp_b.mem_be; o_wdata = mp_b.mem_wdata;
        end
    end

    logic [AW-1:0] lg_addr [4];
    logic [3:0]    lg_be   [4];
    logic [31:0]   lg_wd   [4];
    int            lg_k    [4];
    int            n_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            if_a.req_valid = v; if_a.req_we = we; if_a.req_funct3 = f3;
            if_a.req_addr = addr; if_a.req_wdata = wd;
        end else begin
            if_b.req_valid = v; if_b.req_we = we; if_b.req_funct3 = f3;
            if_b.req_addr = addr; if_b.req_wdata = wd;
        end
    endtask

    // Issue one request, log memory accesses, check latency and response.
    task automatic run_req(input int sel, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_nacc, input string tag);
        int  k;
        bit  seen;
        cur_sel = sel;
        @(negedge clk);
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        drive(sel, 1'b1, we, f3, addr, wd);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        n_acc = 0;
        seen  = 1'b0;
        k     = 1;
        while (!seen && k <= 12) begin
            if (o_mem_req) begin
                if (n_acc < 4) begin
                    lg_addr[n_acc] = o_addr; lg_be[n_acc] = o_be;
                    lg_wd[n_acc] = o_wdata; lg_k[n_acc] = k;
                end
                n_acc++;
            end
            if (o_rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " rdata"}, o_rdata, exp_rdata);
        check({tag, " err"}, 32'(o_rsp_err), 32'(exp_err));
        check({tag, " accesses"}, 32'(n_acc), 32'(exp_nacc));
        @(negedge clk);
        check({tag, " pulse"}, 32'(o_rsp_valid), 32'd0);
    endtask

    int rv_seen;

    initial begin
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        check("reset ready", 32'(if_a.req_ready), 32'd0);
        check("reset mem_req", 32'(mp_a.mem_req), 32'd0);
        check("reset rsp_valid", 32'(if_a.rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset ready a", 32'(if_a.req_ready), 32'd1);
        check("post-reset ready b", 32'(if_b.req_ready), 32'd1);

        // Aligned word store and load.
        run_req(0, 1'b1, 3'd2, 32'h40, 32'h1234_5678, 4, 32'h0, 1'b0, 1, "SW 0x40");
        check("SW 0x40 addr", 32'(lg_addr[0]), 32'h10);
        check("SW 0x40 be", 32'(lg_be[0]), 32'hF);
        check("SW 0x40 wdata", lg_wd[0], 32'h1234_5678);
        check("SW 0x40 acc cycle", 32'(lg_k[0]), 32'd1);
        run_req(0, 1'b0, 3'd2, 32'h40, 32'h0, 4, 32'h1234_5678, 1'b0, 1, "LW 0x40");
        check("LW 0x40 addr", 32'(lg_addr[0]), 32'h10);
        check("LW 0x40 be", 32'(lg_be[0]), 32'hF);

        // Byte loads with sign/zero extension.
        run_req(0, 1'b1, 3'd2, 32'h40, 32'h80FF_7F01, 4, 32'h0, 1'b0, 1, "SW pattern");
        run_req(0, 1'b0, 3'd0, 32'h43, 32'h0, 4, 32'hFFFF_FF80, 1'b0, 1, "LB 0x43");
        check("LB 0x43 be", 32'(lg_be[0]), 32'h8);
        run_req(0, 1'b0, 3'd4, 32'h43, 32'h0, 4, 32'h0000_0080, 1'b0, 1, "LBU 0x43");
        run_req(0, 1'b0, 3'd0, 32'h41, 32'h0, 4, 32'h0000_007F, 1'b0, 1, "LB 0x41");

        // Byte store: unused lanes driven as zero.
        run_req(0, 1'b1, 3'd0, 32'h82, 32'hDEAD_BE55, 4, 32'h0, 1'b0, 1, "SB 0x82");
        check("SB 0x82 be", 32'(lg_be[0]), 32'h4);
        check("SB 0x82 wdata", lg_wd[0], 32'h0055_0000);
        run_req(0, 1'b0, 3'd4, 32'h82, 32'h0, 4, 32'h0000_0055, 1'b0, 1, "LBU 0x82");

        // Split word store and load.
        run_req(0, 1'b1, 3'd2, 32'h44, 32'h0, 4, 32'h0, 1'b0, 1, "SW clear 0x44");
        run_req(0, 1'b1, 3'd2, 32'h43, 32'hAABB_CCDD, 5, 32'h0, 1'b0, 2, "SW split");
        check("SW split addr0", 32'(lg_addr[0]), 32'h10);
        check("SW split be0", 32'(lg_be[0]), 32'h8);
        check("SW split wd0", lg_wd[0], 32'hDD00_0000);
        check("SW split addr1", 32'(lg_addr[1]), 32'h11);
        check("SW split be1", 32'(lg_be[1]), 32'h7);
        check("SW split wd1", lg_wd[1], 32'h00AA_BBCC);
        check("SW split acc1 cycle", 32'(lg_k[1]), 32'd2);
        run_req(0, 1'b0, 3'd2, 32'h43, 32'h0, 5, 32'hAABB_CCDD, 1'b0, 2, "LW split");

        // Wrap-around of the second word address.
        run_req(0, 1'b1, 3'd2, 32'hFFC, 32'h8100_0000, 4, 32'h0, 1'b0, 1, "SW top");
        run_req(0, 1'b1, 3'd2, 32'h000, 32'h0000_00C3, 4, 32'h0, 1'b0, 1, "SW bottom");
        run_req(0, 1'b0, 3'd1, 32'hFFF, 32'h0, 5, 32'hFFFF_C381, 1'b0, 2, "LH wrap");
        check("LH wrap addr0", 32'(lg_addr[0]), 32'h3FF);
        check("LH wrap addr1", 32'(lg_addr[1]), 32'h0);
        check("LH wrap be1", 32'(lg_be[1]), 32'h1);

        // Illegal funct3: error response with no memory access.
        run_req(0, 1'b0, 3'd3, 32'h40, 32'h0, 2, 32'h0, 1'b1, 0, "load f3=3");
        run_req(0, 1'b1, 3'd4, 32'h40, 32'h1, 2, 32'h0, 1'b1, 0, "store f3=4");

        // Misalignment rejected when splitting is disabled.
        run_req(1, 1'b0, 3'd1, 32'h03, 32'h0, 2, 32'h0, 1'b1, 0, "B LH 0x03");
        run_req(1, 1'b0, 3'd1, 32'h02, 32'h0, 4, 32'hFFFF_FFFF, 1'b0, 1, "B LH 0x02");

        // Reset during the second access of a split store.
        cur_sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'd2, 32'h43, 32'h1122_3344);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("abort acc0 mem_req", 32'(o_mem_req), 32'd1);
        @(negedge clk);
        check("abort acc1 mem_req", 32'(o_mem_req), 32'd1);
        check("abort acc1 addr", 32'(o_addr), 32'h11);
        rst_n = 1'b0;
        #1;
        check("abort async mem_req", 32'(o_mem_req), 32'd0);
        check("abort ready low", 32'(o_ready), 32'd0);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid) rv_seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (o_rsp_valid) rv_seen++;
        end
        check("abort no response", 32'(rv_seen), 32'd0);
        check("abort ready after", 32'(o_ready), 32'd1);
        run_req(0, 1'b0, 3'd2, 32'h40, 32'h0, 4, 32'h44FF_7F01, 1'b0, 1, "LW after abort");
        run_req(0, 1'b0, 3'd2, 32'h44, 32'h0, 4, 32'h00AA_BBCC, 1'b0, 1, "LW word1 intact");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
